// File: rtl/conv_window_gen_pkg.sv
// Shared CNN datapath constants and window-generator FSM encoding.
// The conv unit consumes the same definitions.
package conv_window_gen_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int FRACTION_WIDTH = 16;
    localparam int KERNEL_DIM     = 3;
    localparam int CONV_SIZE      = KERNEL_DIM * KERNEL_DIM;

    typedef logic [1:0] state_t;

    localparam state_t ST_FILL  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for the convolution window generator.
interface conv_window_gen_if #(
    parameter int DATA_WIDTH = conv_window_gen_pkg::DATA_WIDTH,
    parameter int CONV_SIZE  = conv_window_gen_pkg::CONV_SIZE
) ();
    logic [DATA_WIDTH-1:0]                pixel;
    logic                                 pixel_valid;
    logic                                 pixel_ready;
    logic [0:CONV_SIZE-1][DATA_WIDTH-1:0] window;
    logic                                 window_valid;
    logic                                 window_ready;
    logic                                 frame_done;

    modport master (
        output pixel, pixel_valid, window_ready,
        input  pixel_ready, window, window_valid, frame_done
    );
    modport slave (
        input  pixel, pixel_valid, window_ready,
        output pixel_ready, window, window_valid, frame_done
    );
endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// KERNEL_DIM-1 row memories addressed by column plus a KxK shift window.
// Everything advances only when a pixel is accepted.
module conv_window_gen_line_buffer #(
    parameter int IMG_WIDTH  = 28,
    parameter int KERNEL_DIM = 3,
    parameter int DATA_WIDTH = 32,
    parameter int COL_W      = $clog2(IMG_WIDTH)
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              shift,
    input  logic [COL_W-1:0]                                  col,
    input  logic [DATA_WIDTH-1:0]                             pixel,
    output logic [0:KERNEL_DIM*KERNEL_DIM-1][DATA_WIDTH-1:0] window
);
    import conv_window_gen_pkg::*;

    logic [DATA_WIDTH-1:0] rows [KERNEL_DIM-1][IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win  [KERNEL_DIM][KERNEL_DIM];
    logic [DATA_WIDTH-1:0] tap  [KERNEL_DIM];

    // tap[0] is the oldest row at this column, tap[K-1] the incoming pixel
    always_comb begin
        for (int r = 0; r < KERNEL_DIM - 1; r++) tap[r] = rows[r][col];
        tap[KERNEL_DIM-1] = pixel;
    end

    always_ff @(posedge clk) begin
        if (shift) begin
            for (int r = 0; r < KERNEL_DIM - 1; r++) rows[r][col] <= tap[r+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < KERNEL_DIM; r++)
                for (int c = 0; c < KERNEL_DIM; c++) win[r][c] <= '0;
        end else if (shift) begin
            for (int r = 0; r < KERNEL_DIM; r++) begin
                for (int c = 0; c < KERNEL_DIM - 1; c++) win[r][c] <= win[r][c+1];
                win[r][KERNEL_DIM-1] <= tap[r];
            end
        end
    end

    always_comb begin
        window = '0;
        for (int r = 0; r < KERNEL_DIM; r++)
            for (int c = 0; c < KERNEL_DIM; c++) window[r*KERNEL_DIM+c] = win[r][c];
    end
endmodule

// File: rtl/conv_window_gen.sv
// Stride-1, unpadded KxK window generator over a raster pixel stream,
// with a single output register and frame-boundary tracking.
module conv_window_gen #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int KERNEL_DIM = conv_window_gen_pkg::KERNEL_DIM,
    parameter int DATA_WIDTH = conv_window_gen_pkg::DATA_WIDTH
) (
    input logic               i_clock,
    input logic               i_reset,
    input logic               i_global_enable,
    conv_window_gen_if.slave  bus
);
    import conv_window_gen_pkg::*;

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             window_valid;
    logic             frame_done;
    logic             accept, consume, col_last, row_last, at_window;

    assign bus.pixel_ready  = !window_valid | bus.window_ready;
    assign bus.window_valid = window_valid;
    assign bus.frame_done   = frame_done;

    // enable is folded into both handshakes, so a low enable freezes everything below
    assign accept    = i_global_enable & bus.pixel_valid & bus.pixel_ready;
    assign consume   = i_global_enable & window_valid & bus.window_ready;
    assign col_last  = (col == COL_W'(IMG_WIDTH - 1));
    assign row_last  = (row == ROW_W'(IMG_HEIGHT - 1));
    assign at_window = (row >= ROW_W'(KERNEL_DIM - 1)) && (col >= COL_W'(KERNEL_DIM - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= ST_FILL;
            col          <= '0;
            row          <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= consume && (state == ST_DRAIN);
            if (accept) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last) row <= row_last ? '0 : row + 1'b1;
                window_valid <= at_window;
            end else if (consume) begin
                window_valid <= 1'b0;
            end
            case (state)
                ST_FILL:  if (accept && col_last && row == ROW_W'(KERNEL_DIM - 2)) state <= ST_RUN;
                ST_RUN:   if (accept && col_last && row_last) state <= ST_DRAIN;
                ST_DRAIN: if (consume) state <= ST_FILL;
                default:  state <= ST_FILL;
            endcase
        end
    end

    conv_window_gen_line_buffer #(
        .IMG_WIDTH  (IMG_WIDTH),
        .KERNEL_DIM (KERNEL_DIM),
        .DATA_WIDTH (DATA_WIDTH),
        .COL_W      (COL_W)
    ) u_line_buffer (
        .clk    (i_clock),
        .rst    (i_reset),
        .shift  (accept),
        .col    (col),
        .pixel  (bus.pixel),
        .window (bus.window)
    );
endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter IMG_WIDTH, default 28: input feature-map columns, ≥ KERNEL_DIM.
REQ-002 Parameter IMG_HEIGHT, default 28: input feature-map rows, ≥ KERNEL_DIM.
REQ-003 Parameter KERNEL_DIM, default 3: window edge; CONV_SIZE = KERNEL_DIM*KERNEL_DIM (9).
REQ-004 Parameter DATA_WIDTH, default 32: pixel width, fixed-point, passed through unmodified.
REQ-005 i_clock  input  1  sole clock, all state on rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_global_enable  input  1  when low, freezes all state; no transfers occur on either port.
REQ-008 i_pixel  input  DATA_WIDTH  raster-order pixel, row-major, frame top-left first.
REQ-009 i_pixel_valid  input  1  i_pixel holds a valid pixel.
REQ-010 o_pixel_ready  output  1  block accepts i_pixel this cycle.
REQ-011 o_window  output  DATA_WIDTH x [0:CONV_SIZE-1]  window, index r*KERNEL_DIM+c, r=0 top (oldest) row, c=0 leftmost column.
REQ-012 o_window_valid  output  1  o_window holds a valid window.
REQ-013 i_window_ready  input  1  downstream conv stage consumes o_window this cycle.
REQ-014 o_frame_done  output  1  one-cycle pulse when the last window of a frame is consumed.

Function
REQ-015 Pixel accepted when i_global_enable & i_pixel_valid & o_pixel_ready; window consumed when i_global_enable & o_window_valid & i_window_ready.
REQ-016 o_pixel_ready = !o_window_valid | i_window_ready (single output register; accept and consume allowed in the same cycle).
REQ-017 Stride 1, no padding: exactly (IMG_HEIGHT-KERNEL_DIM+1)*(IMG_WIDTH-KERNEL_DIM+1) windows per frame.
REQ-018 Column counter 0..IMG_WIDTH-1 and row counter 0..IMG_HEIGHT-1 advance only on accept; column wraps to 0 and row increments at IMG_WIDTH-1; both wrap to 0 after the last frame pixel.
REQ-019 Accepting the pixel at (row ≥ KERNEL_DIM-1, col ≥ KERNEL_DIM-1) sets o_window_valid the next cycle with that pixel at o_window[CONV_SIZE-1]; latency exactly 1 cycle.
REQ-020 Accepting any other pixel updates line buffers only; o_window_valid clears if current window consumed same cycle.
REQ-021 o_window and o_window_valid hold stable while o_window_valid=1 and i_window_ready=0.
REQ-022 FSM states: FILL (rows 0..KERNEL_DIM-2), RUN (windows being produced), DRAIN (last frame pixel accepted, final window pending).
REQ-023 FILL→RUN on accept of pixel (KERNEL_DIM-2, IMG_WIDTH-1); RUN→DRAIN on accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1); DRAIN→FILL on consumption of final window, same cycle o_frame_done pulses for the following cycle.
REQ-024 In DRAIN o_pixel_ready follows REQ-016, so the first pixel of the next frame may be accepted in the consume cycle; back-to-back frames without bubbles.
REQ-025 Line-buffer contents from a previous frame never appear in a window of the next frame.
REQ-026 Pixel data copied bit-exact; no arithmetic, no saturation.

Reset
REQ-027 On i_reset=1: state FILL, counters 0, o_window_valid 0, o_frame_done 0, o_window all zero; line-buffer contents need not clear.
REQ-028 Reset mid-frame discards the partial frame; first pixel accepted after reset is frame pixel (0,0).
REQ-029 i_reset takes precedence over i_global_enable.

Structure
REQ-030 DATA_WIDTH, FRACTION_WIDTH, CONV_SIZE, KERNEL_DIM defaults and the FSM state enum live in the shared CNN package, consumed identically by the conv unit.
REQ-031 One sub-module, line_buffer: KERNEL_DIM-1 row FIFOs of depth IMG_WIDTH plus a KERNEL_DIM x KERNEL_DIM shift window, shifting only on accept.

Verification
REQ-032 5x5 frame, K=3, pixels 0..24, ready always 1 → 9 windows; first {0,1,2,5,6,7,10,11,12} one cycle after pixel 12 accepted; last {12,13,14,17,18,19,22,23,24}; o_frame_done single pulse.
REQ-033 Same frame, i_window_ready low 4 cycles at window 2 → o_pixel_ready 0, o_window {1,2,3,6,7,8,11,12,13} stable, no pixel lost, window sequence unchanged.
REQ-034 Two back-to-back frames (0..24 then 100..124) → 18 windows; second frame's first window {100,101,102,105,106,107,110,111,112}; no mixed-frame windows.
REQ-035 i_reset pulsed after pixel 17 accepted, then pixels 50..74 → o_window_valid 0 during reset; first window {50,51,52,55,56,57,60,61,62}.
REQ-036 i_global_enable low 3 cycles mid-frame with i_pixel_valid=1 → counters, outputs frozen; output sequence identical to REQ-032.
